// File: rtl/instr_prefetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue_pkg
//   Shared definitions for the instruction prefetch queue: data width, default
//   PC increment / reset PC, FSM state encoding, the {pc, instr} queue entry
//   layout and the PC advance helper.
// -----------------------------------------------------------------------------
package instr_prefetch_queue_pkg;

    localparam int XLEN = 16;

    localparam logic [XLEN-1:0] PC_INC_DEF   = 16'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 16'h0000;

    // Request-side state: RUN = nothing outstanding, WAIT = outstanding request
    // whose data will be kept, DISCARD = outstanding request whose data is stale.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } pf_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } pf_entry_t;

    // Next sequential PC; wraps naturally at 16 bits (16'hFFFC + 4 = 16'h0000).
    function automatic logic [XLEN-1:0] pc_advance(input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] inc);
        return pc + inc;
    endfunction

endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue_fifo
//   DEPTH x 32-bit synchronous FIFO holding {pc, instr} entries for the
//   prefetch queue. Pointers carry one extra wrap bit so full and empty are
//   distinguishable. Flush has priority over push and pop.
//   Also computes the head entry as it will be after this edge, so the top
//   can register its fetch-facing outputs with one-cycle ack-to-valid latency.
//
// Ports
//   clk_i         clock
//   rst_ni        synchronous active-low reset
//   push_i        write push_data_i at the tail (ignored when full)
//   push_data_i   {pc, instr} entry to write
//   pop_i         advance the head (ignored when empty)
//   flush_i       empty the queue
//   count_o       registered number of entries held
//   count_next_o  number of entries after this edge
//   head_load_o   queue will be non-empty after this edge
//   head_next_o   head entry after this edge (meaningful when head_load_o)
// -----------------------------------------------------------------------------
module instr_prefetch_queue_fifo
    import instr_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      push_i,
    input  logic [2*XLEN-1:0]         push_data_i,
    input  logic                      pop_i,
    input  logic                      flush_i,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [$clog2(DEPTH):0]    count_next_o,
    output logic                      head_load_o,
    output logic [2*XLEN-1:0]         head_next_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);

    logic [2*XLEN-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       wr_ptr_d;
    logic [AW:0]       rd_ptr_q;
    logic [AW:0]       rd_ptr_d;
    logic [AW:0]       count_q;
    logic [AW:0]       count_d;
    logic              full_s;
    logic              empty_s;
    logic              do_push_s;
    logic              do_pop_s;
    logic [AW-1:0]     wr_idx_s;
    logic [AW-1:0]     rd_idx_d_s;

    // Pointer/count next-state and look-ahead of the post-edge head entry.
    always_comb begin
        full_s    = (count_q == DEPTH_C);
        empty_s   = (count_q == PTR_ZERO);
        do_push_s = push_i && !full_s && !flush_i;
        do_pop_s  = pop_i && !empty_s && !flush_i;

        if (flush_i) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
        end else begin
            wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_d = do_pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        end

        count_d      = wr_ptr_d - rd_ptr_d;
        wr_idx_s     = wr_ptr_q[AW-1:0];
        rd_idx_d_s   = rd_ptr_d[AW-1:0];
        count_next_o = count_d;
        head_load_o  = (count_d != PTR_ZERO);

        // The new head can be the slot being written this very edge (queue was
        // empty, or drains to empty and refills); take the write data then.
        if (do_push_s && (wr_idx_s == rd_idx_d_s)) begin
            head_next_o = push_data_i;
        end else begin
            head_next_o = mem_q[rd_idx_d_s];
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= PTR_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {(2*XLEN){1'b0}};
            end
        end else if (do_push_s) begin
            mem_q[wr_idx_s] <= push_data_i;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
//   Prefetch buffer in front of the fetch stage. Issues one 16-bit read at a
//   time to instruction memory over req/ack, queues returned words with their
//   PCs and presents one instruction per cycle to fetch. Handles the execute
//   redirect (PCSrcE/PC_TargetE) and the hazard-unit stall (StallF).
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-low reset
//   PCSrcE       redirect request from execute (highest priority)
//   PC_TargetE   redirect target
//   StallF       fetch holds; head is not popped
//   InstrF       head instruction
//   PCF          PC of head instruction
//   pc_plus4F    PCF + PC_INC
//   InstrValidF  head entry valid; low means fetch inserts a bubble
//   imem_req     read request, held until imem_ack
//   imem_addr    read address, stable while imem_req is high
//   imem_ack     transfer completes on an edge with imem_req && imem_ack
//   imem_rdata   read data, valid with imem_ack
//   q_count      entries currently held
// -----------------------------------------------------------------------------
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  PC_INC   = PC_INC_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    PCSrcE,
    input  logic [XLEN-1:0]         PC_TargetE,
    input  logic                    StallF,
    output logic [XLEN-1:0]         InstrF,
    output logic [XLEN-1:0]         PCF,
    output logic [XLEN-1:0]         pc_plus4F,
    output logic                    InstrValidF,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_ack,
    input  logic [XLEN-1:0]         imem_rdata,
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    pf_state_e          state_q;
    logic [XLEN-1:0]    fetch_pc_q;
    logic               imem_req_q;
    logic [XLEN-1:0]    imem_addr_q;
    logic [XLEN-1:0]    instr_q;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    pc_plus4_q;
    logic               valid_q;

    logic               xfer_s;
    logic               push_s;
    logic               pop_s;
    logic               can_issue_s;
    logic [CW-1:0]      count_s;
    logic [CW-1:0]      count_next_s;
    logic               head_load_s;
    logic [2*XLEN-1:0]  head_next_raw_s;
    pf_entry_t          head_next_s;

    assign head_next_s = head_next_raw_s;

    // Handshake decode, queue push/pop and issue credit.
    always_comb begin
        xfer_s = imem_req_q && imem_ack;

        // Only a WAIT-state transfer carries live data; a redirect on the same
        // edge makes it stale.
        if (!PCSrcE && (state_q == ST_WAIT) && xfer_s) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end

        if (!PCSrcE && valid_q && !StallF) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end

        // A request issued at this edge stays pending afterwards, so it needs a
        // free slot after this edge's push/pop: q_count + pending < DEPTH.
        can_issue_s = (count_next_s < DEPTH_C);
    end

    instr_prefetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (rst),
        .push_i       (push_s),
        .push_data_i  ({fetch_pc_q, imem_rdata}),
        .pop_i        (pop_s),
        .flush_i      (PCSrcE),
        .count_o      (count_s),
        .count_next_o (count_next_s),
        .head_load_o  (head_load_s),
        .head_next_o  (head_next_raw_s)
    );

    // Request FSM with fetch_pc and registered imem_req/imem_addr. While a
    // request is in flight fetch_pc is the address of that request (WAIT) or
    // the address to issue once the stale request completes (DISCARD).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            fetch_pc_q  <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 16'h0000;
        end else if (PCSrcE) begin
            fetch_pc_q <= PC_TargetE;
            if (imem_req_q && !imem_ack) begin
                // Request still in flight: keep req/addr stable, drop its data later.
                state_q <= ST_DISCARD;
            end else begin
                // Nothing left in flight and the queue is being flushed, so the
                // target is requested right away (visible the next cycle).
                state_q     <= ST_WAIT;
                imem_req_q  <= 1'b1;
                imem_addr_q <= PC_TargetE;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (can_issue_s) begin
                        state_q     <= ST_WAIT;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= fetch_pc_q;
                    end else begin
                        imem_req_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (xfer_s) begin
                        fetch_pc_q <= pc_advance(fetch_pc_q, PC_INC);
                        if (can_issue_s) begin
                            // Back-to-back: keep req high with the next address.
                            imem_addr_q <= pc_advance(fetch_pc_q, PC_INC);
                        end else begin
                            state_q    <= ST_RUN;
                            imem_req_q <= 1'b0;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (xfer_s) begin
                        if (can_issue_s) begin
                            state_q     <= ST_WAIT;
                            imem_addr_q <= fetch_pc_q;
                        end else begin
                            state_q    <= ST_RUN;
                            imem_req_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Fetch-facing head registers; they hold their last value while empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            instr_q    <= 16'h0000;
            pc_q       <= 16'h0000;
            pc_plus4_q <= 16'h0000;
        end else begin
            valid_q <= head_load_s;
            if (head_load_s) begin
                instr_q    <= head_next_s.instr;
                pc_q       <= head_next_s.pc;
                pc_plus4_q <= pc_advance(head_next_s.pc, PC_INC);
            end
        end
    end

    assign InstrF      = instr_q;
    assign PCF         = pc_q;
    assign pc_plus4F   = pc_plus4_q;
    assign InstrValidF = valid_q;
    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign q_count     = count_s;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_queue
//   Self-checking bench: a per-cycle vector table (zero-wait memory) followed
//   by hand-written sequences with a configurable-latency memory model. Every
//   instruction consumed by fetch is compared against a scoreboard of the
//   expected sequential PC stream, reseeded on reset and on each redirect.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_queue;

    logic        clk;
    logic        rst;
    logic        PCSrcE;
    logic [15:0] PC_TargetE;
    logic        StallF;
    logic [15:0] InstrF;
    logic [15:0] PCF;
    logic [15:0] pc_plus4F;
    logic        InstrValidF;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [2:0]  q_count;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    instr_prefetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .PCSrcE      (PCSrcE),
        .PC_TargetE  (PC_TargetE),
        .StallF      (StallF),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .pc_plus4F   (pc_plus4F),
        .InstrValidF (InstrValidF),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .q_count     (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Memory model: mem_lat == 0 acks in the same cycle as req; otherwise
    // ack rises after req has been high for mem_lat cycles.
    int   mem_lat = 0;
    int   lat_cnt;
    logic lat_ack_r;

    always @(posedge clk) begin
        if (!rst || mem_lat == 0) begin
            lat_ack_r <= 1'b0;
            lat_cnt   <= 0;
        end else if (lat_ack_r && imem_req) begin
            lat_ack_r <= 1'b0;
            lat_cnt   <= 0;
        end else if (imem_req) begin
            if (lat_cnt >= mem_lat - 1) lat_ack_r <= 1'b1;
            else                        lat_cnt   <= lat_cnt + 1;
        end else begin
            lat_ack_r <= 1'b0;
            lat_cnt   <= 0;
        end
    end

    assign imem_ack   = (mem_lat == 0) ? imem_req : lat_ack_r;
    assign imem_rdata = mem_fn(imem_addr);

    // Scoreboard of expected {pc, instr} in consumption order.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } sb_t;
    sb_t         sb_q[$];
    logic [15:0] model_pc;

    task automatic sb_refill();
        while (sb_q.size() < 16) begin
            sb_q.push_back({model_pc, mem_fn(model_pc)});
            model_pc = model_pc + 16'd4;
        end
    endtask

    task automatic sb_reset(input logic [15:0] pc);
        sb_q.delete();
        model_pc = pc;
        sb_refill();
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Previous negedge sample, for the address-stability check.
    logic        prev_ok = 1'b0;
    logic        prev_req;
    logic        prev_ack;
    logic        prev_rst;
    logic [15:0] prev_addr;

    // One clock: monitor at negedge (pop scoreboard, address stability), then
    // return 1 time unit after the rising edge.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        if (rst && InstrValidF && !StallF && !PCSrcE) begin
            e = sb_q.pop_front();
            chk("sb_pc", PCF, e.pc);
            chk("sb_instr", InstrF, e.instr);
            pops++;
            sb_refill();
        end
        if (prev_ok && prev_req && !prev_ack && prev_rst) begin
            chk("req_hold", {15'd0, imem_req}, 16'd1);
            chk("addr_hold", imem_addr, prev_addr);
        end
        prev_ok   = 1'b1;
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_rst  = rst;
        prev_addr = imem_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        mem_lat    = lat;
        rst        = 1'b0;
        PCSrcE     = 1'b0;
        StallF     = 1'b0;
        PC_TargetE = 16'h0000;
        sb_reset(16'h0000);
        tick();
        rst = 1'b1;
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [15:0] target;
        logic        stall;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [2:0]  e_cnt;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        logic [15:0] e_plus4;
    } vec_t;

    vec_t vecs[15];
    int   found;
    int   pops0;

    initial begin
        rst        = 1'b0;
        PCSrcE     = 1'b0;
        PC_TargetE = 16'h0000;
        StallF     = 1'b0;
        model_pc   = 16'h0000;

        // Zero-wait memory, one row per cycle: inputs | req addr valid cnt pc instr plus4
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0000,         16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 3'd0, 16'h0000, 16'h0000,         16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b1, 3'd1, 16'h0000, mem_fn(16'h0000), 16'h0004};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0008, 1'b1, 3'd1, 16'h0004, mem_fn(16'h0004), 16'h0008};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C, 1'b1, 3'd2, 16'h0004, mem_fn(16'h0004), 16'h0008};
        vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 1'b1, 3'd3, 16'h0004, mem_fn(16'h0004), 16'h0008};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b1, 3'd4, 16'h0004, mem_fn(16'h0004), 16'h0008};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b1, 3'd4, 16'h0004, mem_fn(16'h0004), 16'h0008};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0014, 1'b1, 3'd3, 16'h0008, mem_fn(16'h0008), 16'h000C};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0018, 1'b1, 3'd3, 16'h000C, mem_fn(16'h000C), 16'h0010};
        // Redirect on the same edge as an ack and a pop.
        vecs[10] = '{1'b1, 1'b1, 16'h0100, 1'b0, 1'b1, 16'h0100, 1'b0, 3'd0, 16'h000C, mem_fn(16'h000C), 16'h0010};
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0104, 1'b1, 3'd1, 16'h0100, mem_fn(16'h0100), 16'h0104};
        // Redirect to the top of the address space: PC wrap.
        vecs[12] = '{1'b1, 1'b1, 16'hFFFC, 1'b1, 1'b1, 16'hFFFC, 1'b0, 3'd0, 16'h0100, mem_fn(16'h0100), 16'h0104};
        vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 3'd1, 16'hFFFC, mem_fn(16'hFFFC), 16'h0000};
        vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b1, 3'd1, 16'h0000, mem_fn(16'h0000), 16'h0004};

        mem_lat = 0;
        for (int i = 0; i < 15; i++) begin
            rst        = vecs[i].rst;
            PCSrcE     = vecs[i].redir;
            PC_TargetE = vecs[i].target;
            StallF     = vecs[i].stall;
            if (!vecs[i].rst)     sb_reset(16'h0000);
            else if (vecs[i].redir) sb_reset(vecs[i].target);
            tick();
            chk($sformatf("v%0d_req", i),   {15'd0, imem_req},    {15'd0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),  imem_addr,            vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), {15'd0, InstrValidF}, {15'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_cnt", i),   {13'd0, q_count},     {13'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d_pc", i),    PCF,                  vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i), InstrF,               vecs[i].e_instr);
            chk($sformatf("v%0d_plus4", i), pc_plus4F,            vecs[i].e_plus4);
        end
        PCSrcE = 1'b0;

        // Zero-wait streaming: two-cycle fill, then one PC per cycle.
        do_reset(0);
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", {15'd0, InstrValidF}, 16'd1);
            chk("stream_pc", PCF, 16'(i * 4));
            tick();
        end

        // 3-cycle memory, fetch stalled: queue fills to DEPTH, requests stop.
        do_reset(3);
        StallF = 1'b1;
        repeat (20) tick();
        chk("full_cnt", {13'd0, q_count}, 16'd4);
        chk("full_req", {15'd0, imem_req}, 16'd0);
        chk("full_pc", PCF, 16'h0000);
        StallF = 1'b0;
        pops0  = pops;
        repeat (40) tick();
        chk("drain_pops_ge8", {15'd0, ((pops - pops0) >= 8) ? 1'b1 : 1'b0}, 16'd1);

        // Redirect to 0x0100 while the request for 0x0010 is outstanding.
        do_reset(3);
        found = 0;
        for (int i = 0; i < 80 && found == 0; i++) begin
            if (imem_req && imem_addr == 16'h0010 && !imem_ack) found = 1;
            else tick();
        end
        chk("wait_0010", 16'(found), 16'd1);
        PCSrcE     = 1'b1;
        PC_TargetE = 16'h0100;
        sb_reset(16'h0100);
        tick();
        PCSrcE = 1'b0;
        chk("disc_req", {15'd0, imem_req}, 16'd1);
        chk("disc_addr", imem_addr, 16'h0010);
        chk("disc_cnt", {13'd0, q_count}, 16'd0);
        chk("disc_valid", {15'd0, InstrValidF}, 16'd0);
        for (int i = 0; i < 40 && !InstrValidF; i++) tick();
        chk("redir_valid", {15'd0, InstrValidF}, 16'd1);
        chk("redir_pc", PCF, 16'h0100);
        chk("redir_plus4", pc_plus4F, 16'h0104);
        repeat (10) tick();

        // Reset while a request is outstanding.
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        chk("pre_rst_req", {15'd0, imem_req}, 16'd1);
        rst = 1'b0;
        sb_reset(16'h0000);
        tick();
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_cnt", {13'd0, q_count}, 16'd0);
        chk("rst_valid", {15'd0, InstrValidF}, 16'd0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_pc", PCF, 16'h0000);
        rst = 1'b1;
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        chk("rst_reissue", {15'd0, imem_req}, 16'd1);
        chk("rst_first_addr", imem_addr, 16'h0000);
        repeat (30) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
